// File: rtl/ezp_stream_arb.sv
// Packet-locked round-robin arbiter: N byte-serial EZPack sources share one sink.
// Optional stall watchdog enabled by defining EZP_ARB_TIMEOUT_EN.
module ezp_stream_arb #(
  parameter int          N_SRC      = 4,
  parameter logic [7:0]  START_BYTE = 8'hAA,
  parameter int          MAX_PD_LEN = 2,
  parameter int          TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*N_SRC-1:0]     i_data,
  input  logic [N_SRC-1:0]       i_valid,
  output logic [N_SRC-1:0]       i_ready,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] o_src,
  output logic                   o_last,
  output logic                   o_drop,
  output logic                   o_abort
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int LEN_W = $clog2(MAX_PD_LEN + 6);

  if (N_SRC < 2 || MAX_PD_LEN < 0 || TIMEOUT < 1) begin : g_param_check
    $error("ezp_stream_arb: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PASS = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SRC_W-1:0]     r_grant;
  logic [SRC_W-1:0]     r_rr;
  logic [SRC_W-1:0]     w_sel;
  logic [SRC_W-1:0]     w_grant_inc;
  logic                 w_sel_vld;
  logic [N_SRC-1:0]     w_start;
  logic [N_SRC-1:0]     w_junk;
  logic [7:0]           w_byte;
  logic [LEN_W-1:0]     r_cnt;
  logic [LEN_W-1:0]     r_pkt_len;
  logic [LEN_W-1:0]     w_hdr_len;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_abort;
  logic                 r_drop;
  logic                 r_abort;

  // Classify every offered byte as a start marker (candidate) or stray data.
  always_comb begin
    w_start = '0;
    w_junk  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_start[k] = i_valid[k] && (i_data[8*k +: 8] == START_BYTE);
      w_junk[k]  = i_valid[k] && (i_data[8*k +: 8] != START_BYTE);
    end
  end

  // Scan downward from the pointer's farthest wrap so the nearest candidate wins.
  always_comb begin
    int j;
    w_sel     = '0;
    w_sel_vld = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j         = int'(r_rr) + k;
      j         = (j >= N_SRC) ? (j - N_SRC) : j;
      w_sel     = w_start[j] ? SRC_W'(j) : w_sel;
      w_sel_vld = w_sel_vld | w_start[j];
    end
  end

  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < N_SRC; k++) begin
      w_byte = (r_grant == SRC_W'(k)) ? i_data[8*k +: 8] : w_byte;
    end
  end

  always_comb begin
    if (int'(w_byte) > MAX_PD_LEN) begin
      w_hdr_len = LEN_W'(MAX_PD_LEN + 5);
    end else begin
      w_hdr_len = LEN_W'(int'(w_byte) + 5);
    end
  end

  assign w_grant_inc = (r_grant == SRC_W'(N_SRC - 1)) ? {SRC_W{1'b0}} : (r_grant + SRC_W'(1));
  // Length byte is the third byte, so o_last can never fire before it is known.
  assign w_last      = (r_state == S_PASS) && (r_cnt == (r_pkt_len - LEN_W'(1))) &&
                       (r_cnt >= LEN_W'(2));

`ifdef EZP_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_stall;

  assign w_abort = (r_state == S_PASS) && !i_valid[r_grant] &&
                   (r_stall == TO_W'(TIMEOUT - 1));

  // Counts only source-side stalls; sink backpressure holds the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= {TO_W{1'b0}};
    end else if ((r_state != S_PASS) || w_xfer || w_abort) begin
      r_stall <= {TO_W{1'b0}};
    end else if (!i_valid[r_grant]) begin
      r_stall <= r_stall + TO_W'(1);
    end else begin
      r_stall <= r_stall;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_data      = 8'h00;
    o_valid     = 1'b0;
    i_ready     = '0;
    w_xfer      = 1'b0;
    if (rst) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          i_ready = w_junk;
          if (w_sel_vld) begin
            w_state_nxt = S_PASS;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PASS: begin
          o_data           = w_byte;
          o_valid          = i_valid[r_grant];
          i_ready[r_grant] = o_ready;
          w_xfer           = i_valid[r_grant] && o_ready;
          if ((w_xfer && w_last) || w_abort) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_PASS;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= {SRC_W{1'b0}};
      r_rr      <= {SRC_W{1'b0}};
      r_cnt     <= {LEN_W{1'b0}};
      r_pkt_len <= LEN_W'(MAX_PD_LEN + 5);
      r_drop    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_drop  <= (r_state == S_IDLE) && (|w_junk);
      r_abort <= w_abort;
      if ((r_state == S_IDLE) && w_sel_vld) begin
        r_grant <= w_sel;
      end else begin
        r_grant <= r_grant;
      end
      if (w_xfer) begin
        if (w_last) begin
          r_cnt <= {LEN_W{1'b0}};
          r_rr  <= w_grant_inc;
        end else begin
          r_cnt <= r_cnt + LEN_W'(1);
          r_rr  <= r_rr;
        end
        if (r_cnt == LEN_W'(2)) begin
          r_pkt_len <= w_hdr_len;
        end else begin
          r_pkt_len <= r_pkt_len;
        end
      end else if (w_abort) begin
        r_cnt     <= {LEN_W{1'b0}};
        r_rr      <= w_grant_inc;
        r_pkt_len <= r_pkt_len;
      end else begin
        r_cnt     <= r_cnt;
        r_rr      <= r_rr;
        r_pkt_len <= r_pkt_len;
      end
    end
  end

  assign o_src   = r_grant;
  assign o_last  = w_last && !rst;
  assign o_drop  = r_drop;
  assign o_abort = r_abort;

endmodule
